// File: rtl/layer_lut_scheduler.sv
// Time-multiplexed LUT layer: one neuron per cycle through a shared LUT port,
// with a runtime-writable connectivity table selecting each neuron's fan-in features.
module layer_lut_scheduler #(
  parameter int IN_FEATURES = 64,
  parameter int IN_BITS     = 2,
  parameter int FANIN       = 4,
  parameter int NEURONS     = 32,
  parameter int OUT_BITS    = 2,
  localparam int AW = $clog2(NEURONS * FANIN),
  localparam int FW = $clog2(IN_FEATURES),
  localparam int NW = $clog2(NEURONS),
  localparam int LW = FANIN * IN_BITS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [IN_FEATURES*IN_BITS-1:0]  in_data,
  input  logic                            cfg_we,
  input  logic [AW-1:0]                   cfg_addr,
  input  logic [FW-1:0]                   cfg_wdata,
  output logic                            cfg_err,
  output logic                            lut_re,
  output logic [NW-1:0]                   lut_neuron,
  output logic [LW-1:0]                   lut_addr,
  input  logic [OUT_BITS-1:0]             lut_rdata,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NEURONS*OUT_BITS-1:0]     out_data
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                         state, state_nxt;
  logic [NW-1:0]                  n, n_d;
  logic                           cap_valid;
  logic [IN_FEATURES*IN_BITS-1:0] data_q;
  logic [FW-1:0]                  conn [NEURONS*FANIN];
  logic                           pend_valid;
  logic [AW-1:0]                  pend_addr;
  logic [FW-1:0]                  pend_data;
  logic                           addr_ok, data_ok, cfg_ok, accept;

  // Range checks collapse to constants when the field width exactly covers the range.
  if ((1 << AW) == NEURONS * FANIN) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_chk
    assign addr_ok = (32'(cfg_addr) < NEURONS * FANIN);
  end

  if ((1 << FW) == IN_FEATURES) begin : g_data_full
    assign data_ok = 1'b1;
  end else begin : g_data_chk
    assign data_ok = (32'(cfg_wdata) < IN_FEATURES);
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign cfg_ok    = cfg_we && (state == IDLE) && addr_ok && data_ok;

  always_comb begin
    state_nxt  = state;
    lut_re     = 1'b0;
    lut_neuron = '0;
    lut_addr   = '0;
    case (state)
      IDLE:  if (accept) state_nxt = RUN;
      RUN: begin
        lut_re     = 1'b1;
        lut_neuron = n;
        for (int unsigned k = 0; k < FANIN; k++) begin
          lut_addr[k*IN_BITS +: IN_BITS] =
            data_q[32'(conn[AW'(32'(n) * FANIN + k)]) * IN_BITS +: IN_BITS];
        end
        if (n == NW'(NEURONS - 1)) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      n         <= '0;
      n_d       <= '0;
      cap_valid <= 1'b0;
      data_q    <= '0;
      out_data  <= '0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg_err   <= cfg_we && !cfg_ok;
      cap_valid <= (state == RUN);
      n_d       <= n;
      if (accept) begin
        data_q <= in_data;
        n      <= '0;
      end else if (state == RUN) begin
        n <= n + NW'(1);
      end
      if (cap_valid) out_data[n_d*OUT_BITS +: OUT_BITS] <= lut_rdata;
    end
  end

  // A write arriving with an accepted vector is parked until DONE so the
  // vector in flight keeps reading the table as it was at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NEURONS * FANIN; i++) conn[i] <= FW'(i % IN_FEATURES);
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      if (cfg_ok && accept) begin
        pend_valid <= 1'b1;
        pend_addr  <= cfg_addr;
        pend_data  <= cfg_wdata;
      end else if (cfg_ok) begin
        conn[cfg_addr] <= cfg_wdata;
      end
      if (pend_valid && (state == DONE)) begin
        conn[pend_addr] <= pend_data;
        pend_valid      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_layer_lut_scheduler.sv
// Scoreboarded bench for layer_lut_scheduler: stimulus pushes expected out_data,
// a negedge monitor pops and compares on every output handshake.
module tb_layer_lut_scheduler;
  localparam int IN_FEATURES = 64;
  localparam int IN_BITS     = 2;
  localparam int FANIN       = 4;
  localparam int NEURONS     = 32;
  localparam int OUT_BITS    = 2;

  // VEC_A: feature f = f mod 4.  VEC_B: feature f = (f/4) mod 4.
  localparam logic [127:0] VEC_A  = {16{8'hE4}};
  localparam logic [127:0] VEC_B  = {4{32'hFFAA5500}};
  localparam logic [63:0]  OUT_E4 = {8{8'hE4}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         cfg_we = 1'b0;
  logic [6:0]   cfg_addr = '0;
  logic [5:0]   cfg_wdata = '0;
  logic         cfg_err;
  logic         lut_re;
  logic [4:0]   lut_neuron;
  logic [7:0]   lut_addr;
  logic [1:0]   lut_rdata = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [63:0]  out_data;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          re_cnt = 0;
  int          hs_cyc = 0;
  logic [63:0] sb [$];

  layer_lut_scheduler #(
    .IN_FEATURES(IN_FEATURES), .IN_BITS(IN_BITS), .FANIN(FANIN),
    .NEURONS(NEURONS), .OUT_BITS(OUT_BITS)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
    .lut_re(lut_re), .lut_neuron(lut_neuron), .lut_addr(lut_addr), .lut_rdata(lut_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // LUT model: result is the low input field of the address, one cycle later.
  always @(posedge clk) lut_rdata <= lut_addr[1:0];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("spurious_out_valid", {63'b0, out_valid}, 64'd0);
      else check("out_data", out_data, sb.pop_front());
    end
  end

  task automatic step();
    if (lut_re) re_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [127:0] d, input logic [63:0] exp, input bit push);
    int g = 0;
    while (!in_ready && g < 200) begin step(); g++; end
    check("in_ready_wait", {63'b0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    if (push) sb.push_back(exp);
    hs_cyc = cyc;
    step();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    re_cnt   = 0;
  endtask

  // Latency is counted from the cycle in which the input handshake is presented.
  task automatic finish_vec();
    int g = 0;
    while (!out_valid && g < 100) begin step(); g++; end
    check("out_valid_timeout", {63'b0, out_valid}, 64'd1);
    check("latency", 64'(cyc - hs_cyc), 64'd34);
    check("lut_re_burst", 64'(re_cnt), 64'd32);
    if (out_ready) step();
  endtask

  task automatic cfg_write(input logic [6:0] a, input logic [5:0] d, input logic exp_err);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    step();
    cfg_we = 1'b0;
    check("cfg_err", {63'b0, cfg_err}, {63'b0, exp_err});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, ov, hs, run;
    logic prev_ir, prev_re;
    int rises [$];
    int bursts [$];

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",   {63'b0, in_ready},  64'd1);
    check("rst_out_valid",  {63'b0, out_valid}, 64'd0);
    check("rst_lut_re",     {63'b0, lut_re},    64'd0);
    check("rst_lut_neuron", 64'(lut_neuron),    64'd0);
    check("rst_lut_addr",   64'(lut_addr),      64'd0);
    check("rst_cfg_err",    {63'b0, cfg_err},   64'd0);
    check("rst_out_data",   out_data,           64'd0);
    @(negedge clk) rst = 1'b0;
    step();

    // Default table: neuron n reads feature 4n.
    issue(VEC_A, 64'd0, 1'b1);
    finish_vec();
    issue(VEC_B, OUT_E4, 1'b1);
    cfg_write(7'd8, 6'd0, 1'b1);     // rejected while running
    finish_vec();

    // Write with accepted vector: this vector uses old conn[4]=4.
    cfg_we = 1'b1; cfg_addr = 7'd4; cfg_wdata = 6'd2;
    issue(VEC_B, OUT_E4, 1'b1);
    check("cfg_err_simul", {63'b0, cfg_err}, 64'd0);
    finish_vec();
    issue(VEC_B, 64'hE4E4E4E4E4E4E4E0, 1'b1);
    finish_vec();

    cfg_write(7'd0, 6'd61, 1'b0);
    cfg_write(7'd1, 6'd62, 1'b0);
    cfg_write(7'd2, 6'd63, 1'b0);
    cfg_write(7'd3, 6'd60, 1'b0);
    issue(VEC_A, 64'h9, 1'b1);
    check("lut_addr_n0", {50'b0, lut_re, lut_neuron, lut_addr}, {50'b0, 1'b1, 5'd0, 8'h39});
    finish_vec();

    // Backpressure in DONE.
    out_ready = 1'b0;
    issue(VEC_A, 64'h9, 1'b1);
    finish_vec();
    for (int i = 0; i < 10; i++) begin
      check("hold_flags", {62'b0, out_valid, in_ready}, 64'b10);
      check("hold_data", out_data, 64'h9);
      if (i == 4) check("hold_cfg_err_pulse", {63'b0, cfg_err}, 64'd1);
      if (i == 5) check("hold_cfg_err_clear", {63'b0, cfg_err}, 64'd0);
      if (i == 4) cfg_we = 1'b0;
      if (i == 3) begin cfg_we = 1'b1; cfg_addr = 7'd0; cfg_wdata = 6'd0; end
      step();
    end
    out_ready = 1'b1;
    step();
    check("in_ready_after_out_hs", {63'b0, in_ready}, 64'd1);
    issue(VEC_A, 64'h9, 1'b1);
    finish_vec();

    // Reset mid-run at n=17.
    issue(VEC_B, 64'd0, 1'b0);
    g = 0;
    while (!(lut_re && lut_neuron == 5'd17) && g < 60) begin step(); g++; end
    check("reached_n17", 64'(lut_neuron), 64'd17);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_flags", {60'b0, in_ready, out_valid, lut_re, cfg_err}, 64'b1000);
    check("mid_rst_lut_neuron", 64'(lut_neuron), 64'd0);
    check("mid_rst_lut_addr",   64'(lut_addr),   64'd0);
    check("mid_rst_out_data",   out_data,        64'd0);
    @(negedge clk) rst = 1'b0;
    step();
    ov = 0;
    repeat (40) begin
      if (out_valid) ov++;
      step();
    end
    check("no_out_valid_after_reset", 64'(ov), 64'd0);
    issue(VEC_B, OUT_E4, 1'b1);
    finish_vec();

    // Back-to-back vectors.
    in_data  = VEC_B;
    in_valid = 1'b1;
    repeat (3) sb.push_back(OUT_E4);
    hs = 0; run = 0;
    prev_ir = in_ready;
    prev_re = lut_re;
    for (int c = 0; c < 115; c++) begin
      if (in_ready && in_valid) hs++;
      step();
      if (hs == 3) in_valid = 1'b0;
      if (in_ready && !prev_ir) rises.push_back(cyc);
      if (lut_re) run++;
      else if (prev_re) begin bursts.push_back(run); run = 0; end
      prev_ir = in_ready;
      prev_re = lut_re;
    end
    in_valid = 1'b0;
    check("b2b_rise_count", 64'(rises.size()), 64'd3);
    if (rises.size() == 3) begin
      check("b2b_gap0", 64'(rises[1] - rises[0]), 64'd35);
      check("b2b_gap1", 64'(rises[2] - rises[1]), 64'd35);
    end
    check("b2b_burst_count", 64'(bursts.size()), 64'd3);
    foreach (bursts[i]) check("b2b_burst_len", 64'(bursts[i]), 64'd32);

    repeat (3) step();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
